// File: rtl/nco_ctrl_pkg.sv
// Shared encodings for the NCO sweep controller.
package nco_ctrl_pkg;

  localparam int CW_W_DEF       = 16;
  localparam int STEP_CNT_W_DEF = 16;
  localparam int DWELL_W_DEF    = 16;

  // cfg_mode encodings; the reserved code 3 behaves as single.
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  // There is no separate advance state: a new point is loaded on the last
  // dwell cycle, so there are no bubble cycles between points.
  typedef enum logic {
    ST_IDLE,
    ST_DWELL
  } state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell down-counter: loaded when a point is applied, expires on its last cycle.
module sweep_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  // Reload on each new point, otherwise count down to zero and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (en && cnt != '0)     cnt <= cnt - DWELL_W'(1);
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep sequencer feeding the NCO tuning words.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int CW_W       = CW_W_DEF,
  parameter int STEP_CNT_W = STEP_CNT_W_DEF,
  parameter int DWELL_W    = DWELL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CW_W-1:0]       cfg_start_word,
  input  logic [CW_W-1:0]       cfg_step_word,
  input  logic [STEP_CNT_W-1:0] cfg_steps,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  input  logic [1:0]            cfg_mode,
  input  logic [CW_W-1:0]       cfg_idle_word,
  input  logic [CW_W-1:0]       cfg_phase_word,
  output logic [CW_W-1:0]       control_word,
  output logic [CW_W-1:0]       phase_control_word,
  output logic                  busy,
  output logic                  step_strobe,
  output logic                  done,
  output logic [STEP_CNT_W-1:0] point_idx
);

  state_t state, state_n;

  // Configuration captured at start; live cfg changes are ignored while busy.
  logic [CW_W-1:0]       start_q, step_q;
  logic [STEP_CNT_W-1:0] steps_q;
  logic [DWELL_W-1:0]    dwell_q;
  logic [1:0]            mode_q;
  logic                  dir_q;      // triangle direction, 1 = walking down

  logic                  go, expire, is_repeat, pass_end, dir_n;
  logic [CW_W-1:0]       cw_n;
  logic [STEP_CNT_W-1:0] idx_n;

  assign go        = (state == ST_IDLE) && start && !abort;
  assign is_repeat = (mode_q == MODE_SAW) || (mode_q == MODE_TRI);

  sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (go || expire),
    .load_val (go ? cfg_dwell : dwell_q),
    .en       (state == ST_DWELL),
    .expire   (expire)
  );

  // Next point: up-step by default, down-step on the triangle return leg,
  // reload of point 0 at the end of a sawtooth/single pass.
  always_comb begin
    idx_n    = point_idx + STEP_CNT_W'(1);
    cw_n     = control_word + step_q;
    dir_n    = dir_q;
    pass_end = 1'b0;
    if (mode_q == MODE_TRI && steps_q != '0) begin
      if (dir_q || point_idx == steps_q) begin
        idx_n    = point_idx - STEP_CNT_W'(1);
        cw_n     = control_word - step_q;
        dir_n    = (idx_n != '0);
        pass_end = (idx_n == '0);
      end
    end else if (point_idx == steps_q) begin
      idx_n    = '0;
      cw_n     = start_q;
      pass_end = 1'b1;
    end
  end

  // Next-state: leave idle on an accepted start, return on abort or end of a single pass.
  always_comb begin
    state_n = state;
    if (state == ST_IDLE) begin
      if (go) state_n = ST_DWELL;
    end else begin
      if (abort || (expire && pass_end && !is_repeat)) state_n = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Output words, flags, point index and latched configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      control_word       <= '0;
      phase_control_word <= '0;
      busy               <= 1'b0;
      step_strobe        <= 1'b0;
      done               <= 1'b0;
      point_idx          <= '0;
      dir_q              <= 1'b0;
      start_q            <= '0;
      step_q             <= '0;
      steps_q            <= '0;
      dwell_q            <= '0;
      mode_q             <= MODE_SINGLE;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      if (state == ST_IDLE) begin
        phase_control_word <= cfg_phase_word;
        point_idx          <= '0;
        dir_q              <= 1'b0;
        if (go) begin
          start_q      <= cfg_start_word;
          step_q       <= cfg_step_word;
          steps_q      <= cfg_steps;
          dwell_q      <= cfg_dwell;
          mode_q       <= cfg_mode;
          control_word <= cfg_start_word;
          busy         <= 1'b1;
          step_strobe  <= 1'b1;
        end else begin
          control_word <= cfg_idle_word;
          busy         <= 1'b0;
        end
      end else if (abort || (expire && pass_end && !is_repeat)) begin
        // Back to idle outputs; only a completed pass reports done.
        control_word       <= cfg_idle_word;
        phase_control_word <= cfg_phase_word;
        busy               <= 1'b0;
        point_idx          <= '0;
        dir_q              <= 1'b0;
        done               <= !abort;
      end else if (expire) begin
        control_word <= cw_n;
        point_idx    <= idx_n;
        dir_q        <= dir_n;
        step_strobe  <= 1'b1;
        done         <= pass_end;
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected cycles queued at stimulus time.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] cfg_start_word = '0, cfg_step_word = '0, cfg_steps = '0, cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_idle_word = 16'h2D00, cfg_phase_word = 16'h4000;
  logic [15:0] control_word, phase_control_word, point_idx;
  logic        busy, step_strobe, done;

  nco_sweep_ctrl #(.CW_W(16), .STEP_CNT_W(16), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_start_word(cfg_start_word), .cfg_step_word(cfg_step_word),
    .cfg_steps(cfg_steps), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .cfg_idle_word(cfg_idle_word), .cfg_phase_word(cfg_phase_word),
    .control_word(control_word), .phase_control_word(phase_control_word),
    .busy(busy), .step_strobe(step_strobe), .done(done), .point_idx(point_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cw, pcw, idx;
    logic        b, s, d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] cw, pcw, idx, input logic b, s, d);
    exp_t e;
    e.cw = cw; e.pcw = pcw; e.idx = idx; e.b = b; e.s = s; e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_idle(input logic d);
    push(cfg_idle_word, cfg_phase_word, 16'h0, 1'b0, 1'b0, d);
  endtask

  // Reference sweep: point k carries start + k*step; done marks each return to point 0.
  task automatic push_run(input int mode, input int ncyc, input logic [15:0] sw, st,
                          input int steps, input int dwell, input logic [15:0] ph);
    int idx = 0, c = 0;
    bit dn = 0, first = 1;
    logic [15:0] w;
    while (c < ncyc) begin
      w = sw + 16'(idx) * st;
      for (int d = 0; d <= dwell && c < ncyc; d++) begin
        push(w, ph, 16'(idx), 1'b1, d == 0, d == 0 && idx == 0 && !first);
        c++;
      end
      first = 0;
      if (mode != 2 || steps == 0) idx = (idx == steps) ? 0 : idx + 1;
      else if (!dn) begin
        if (idx == steps) begin dn = 1; idx = steps - 1; end
        else idx++;
      end else idx--;
      if (idx == 0) dn = 0;
    end
  endtask

  task automatic step_check();
    exp_t e;
    @(negedge clk);
    cyc++;
    e = sb.pop_front();
    chk($sformatf("cw@%0d", cyc), control_word, e.cw);
    chk($sformatf("pcw@%0d", cyc), phase_control_word, e.pcw);
    chk($sformatf("idx@%0d", cyc), point_idx, e.idx);
    chk($sformatf("busy@%0d", cyc), 16'(busy), 16'(e.b));
    chk($sformatf("strobe@%0d", cyc), 16'(step_strobe), 16'(e.s));
    chk($sformatf("done@%0d", cyc), 16'(done), 16'(e.d));
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Run out the queue; optionally poke start and/or a cfg change after cycle poke_at.
  task automatic drain(input int poke_at, input int kind);
    int n = 0;
    while (sb.size() > 0) begin
      step_check();
      n++;
      if (n == poke_at) begin
        if (kind[0]) start = 1'b1;
        if (kind[1]) begin
          cfg_start_word = 16'h7777; cfg_step_word = 16'h0333; cfg_steps = 16'd9;
          cfg_dwell = 16'd5; cfg_mode = 2'd0; cfg_phase_word = 16'hBEEF;
        end
      end
    end
  endtask

  task automatic set_cfg(input logic [15:0] sw, st, steps, dwell, input logic [1:0] mode);
    cfg_start_word = sw; cfg_step_word = st; cfg_steps = steps; cfg_dwell = dwell; cfg_mode = mode;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cw"}, control_word, 16'h0);
    chk({tag, "_pcw"}, phase_control_word, 16'h0);
    chk({tag, "_idx"}, point_idx, 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_strobe"}, 16'(step_strobe), 16'h0);
    chk({tag, "_done"}, 16'(done), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    push_idle(1'b0); push_idle(1'b0);
    drain(0, 0);

    // Single up-sweep, dwell 2 cycles per point.
    set_cfg(16'h1000, 16'h0100, 16'd3, 16'd1, 2'd0);
    start = 1'b1;
    push_run(0, 8, 16'h1000, 16'h0100, 3, 1, 16'h4000);
    push_idle(1'b1); push_idle(1'b0);
    drain(0, 0);

    // Negative step wrapping through zero, one cycle per point.
    set_cfg(16'h0080, 16'hFF00, 16'd2, 16'd0, 2'd0);
    start = 1'b1;
    push_run(0, 3, 16'h0080, 16'hFF00, 2, 0, 16'h4000);
    push_idle(1'b1); push_idle(1'b0);
    drain(0, 0);

    // Triangle; cfg (including phase) rewritten mid-sweep must not disturb it.
    set_cfg(16'h0000, 16'h0010, 16'd2, 16'd0, 2'd2);
    start = 1'b1;
    push_run(2, 10, 16'h0000, 16'h0010, 2, 0, 16'h4000);
    drain(2, 2);
    abort = 1'b1;
    push_idle(1'b0); push_idle(1'b0);
    drain(0, 0);
    cfg_phase_word = 16'h4000;
    push_idle(1'b0); push_idle(1'b0);
    drain(0, 0);

    // Sawtooth with a start pulse while busy, then abort mid-dwell.
    set_cfg(16'h0A00, 16'h0050, 16'd1, 16'd2, 2'd1);
    start = 1'b1;
    push_run(1, 14, 16'h0A00, 16'h0050, 1, 2, 16'h4000);
    drain(5, 1);
    abort = 1'b1;
    push_idle(1'b0); push_idle(1'b0);
    drain(0, 0);

    // start and abort together in idle: stays idle.
    start = 1'b1; abort = 1'b1;
    push_idle(1'b0); push_idle(1'b0);
    drain(0, 0);

    // Async reset between clock edges mid-sweep, then a normal sweep.
    set_cfg(16'h3000, 16'h0010, 16'd5, 16'd3, 2'd0);
    start = 1'b1;
    push_run(0, 3, 16'h3000, 16'h0010, 5, 3, 16'h4000);
    drain(0, 0);
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    chk_zero("rst_held");
    rst = 1'b0;
    push_idle(1'b0);
    drain(0, 0);
    set_cfg(16'h0100, 16'h0001, 16'd1, 16'd0, 2'd0);
    start = 1'b1;
    push_run(0, 2, 16'h0100, 16'h0001, 1, 0, 16'h4000);
    push_idle(1'b1); push_idle(1'b0);
    drain(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
